// File: rtl/tt_probe_3in.sv
// Truth-table probe for a 3-input combinational circuit.
// Sweeps all 8 input vectors, records the response and compares it to a golden code.
module tt_probe_3in #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] expected_tt,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] tt,
  output logic       match,
  output logic [7:0] mismatch_mask,
  output logic       unstable
);

  typedef enum logic [1:0] {IDLE, DRIVE, FINISH} state_t;

  localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] PREV = 4'(SETTLE_CYCLES - 2);

  state_t     state, state_nx;
  logic [2:0] idx;
  logic [3:0] cnt;
  logic [7:0] exp_q;
  logic [7:0] work;
  logic [7:0] work_nx;
  logic       uns_w;
  logic       uns_nx;
  logic       pre;
  logic       win_end;

  assign win_end = (state == DRIVE) && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && !abort) state_nx = DRIVE;
      DRIVE: begin
        if (abort)                          state_nx = IDLE;
        else if (win_end && idx == 3'd7)    state_nx = FINISH;
      end
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Working result including the sample taken on this edge
  always_comb begin
    work_nx      = work;
    work_nx[idx] = dut_out;
    uns_nx       = uns_w | (pre != dut_out);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx           <= '0;
      cnt           <= '0;
      exp_q         <= '0;
      work          <= '0;
      uns_w         <= 1'b0;
      pre           <= 1'b0;
      tt            <= '0;
      match         <= 1'b0;
      mismatch_mask <= '0;
      unstable      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          idx <= '0;
          cnt <= '0;
          if (start && !abort) begin
            exp_q <= expected_tt;
            work  <= '0;
            uns_w <= 1'b0;
          end
        end
        DRIVE: begin
          if (abort) begin
            idx <= '0;
            cnt <= '0;
          end else if (win_end) begin
            work  <= work_nx;
            uns_w <= uns_nx;
            cnt   <= '0;
            if (idx == 3'd7) begin
              tt            <= work_nx;
              match         <= (work_nx == exp_q);
              mismatch_mask <= work_nx ^ exp_q;
              unstable      <= uns_nx;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            if (cnt == PREV) pre <= dut_out;
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          idx <= '0;
          cnt <= '0;
        end
      endcase
    end
  end

  assign {in1, in2, in3} = (state == DRIVE) ? idx : 3'b000;
  assign busy            = (state != IDLE);
  assign done            = (state == FINISH);

endmodule

// File: tb/tb_tt_probe_3in.sv
// Directed bench for tt_probe_3in.
// Hand-computed truth tables for a NOT(all-equal) circuit and a stuck-at-0 circuit.
module tb_tt_probe_3in;

  localparam int S = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] expected_tt;
  logic       dut_out;
  logic       in1, in2, in3;
  logic       busy, done;
  logic [7:0] tt;
  logic       match;
  logic [7:0] mismatch_mask;
  logic       unstable;

  logic mode;
  logic flip;
  int   nvec;
  int   nfail;

  tt_probe_3in #(.SETTLE_CYCLES(S)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .expected_tt   (expected_tt),
    .dut_out       (dut_out),
    .in1           (in1),
    .in2           (in2),
    .in3           (in3),
    .busy          (busy),
    .done          (done),
    .tt            (tt),
    .match         (match),
    .mismatch_mask (mismatch_mask),
    .unstable      (unstable)
  );

  assign dut_out = mode ? 1'b0
                 : (~((in1 == in2) && (in2 == in3)) ^ flip);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input logic [7:0] etx, input logic [7:0] ett,
                       input bit glitch, input bit hold);
    expected_tt = etx;
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    expected_tt = ~etx;
    for (int k = 1; k <= 33; k++) begin
      tick();
      if (glitch && k == 11) flip = 1'b1;
      if (glitch && k == 12) flip = 1'b0;
      if (k % S == 1 && k < 32) begin
        check("in_vec", {29'd0, in1, in2, in3}, k / S);
        check("busy_drive", busy, 1);
      end
      if (k == 31) check("done_early", done, 0);
      if (k == 32) begin
        check("done_pulse", done, 1);
        check("busy_fin", busy, 1);
        check("in_fin", {in1, in2, in3}, 0);
        check("tt", tt, ett);
        check("match", match, (ett == etx));
        check("mask", mismatch_mask, ett ^ etx);
        check("unstable", unstable, glitch);
        start = 1'b0;
      end
      if (k == 33) begin
        check("done_fall", done, 0);
        check("busy_idle", busy, 0);
        check("tt_hold", tt, ett);
      end
    end
  endtask

  initial begin
    int pulses;
    nvec = 0;
    nfail = 0;
    mode = 1'b0;
    flip = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    expected_tt = 8'h00;
    rst = 1'b0;
    #1 rst = 1'b1;
    #11;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tt", tt, 8'h00);
    check("rst_match", match, 0);
    check("rst_mask", mismatch_mask, 8'h00);
    check("rst_uns", unstable, 0);
    check("rst_in", {in1, in2, in3}, 0);
    rst = 1'b0;
    tick();

    sweep(8'h7E, 8'h7E, 0, 0);
    mode = 1'b1;
    sweep(8'h00, 8'h00, 0, 0);
    mode = 1'b0;
    sweep(8'h81, 8'h7E, 0, 0);

    // abort inside the index 3 window
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 14; k++) tick();
    check("ab_in_pre", {in1, in2, in3}, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_in", {in1, in2, in3}, 0);
    check("ab_tt", tt, 8'h7E);
    check("ab_match", match, 0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) pulses++;
      tick();
    end
    check("ab_nodone", pulses, 0);

    // start and abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", busy, 0);

    // reset inside the index 5 window
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 22; k++) tick();
    check("rs_in_pre", {in1, in2, in3}, 5);
    #2 rst = 1'b1;
    #1;
    check("rs_busy", busy, 0);
    check("rs_in", {in1, in2, in3}, 0);
    check("rs_tt", tt, 8'h00);
    check("rs_mask", mismatch_mask, 8'h00);
    check("rs_match", match, 0);
    #1 rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (done || busy) pulses++;
      tick();
    end
    check("rs_idle", pulses, 0);
    sweep(8'h7E, 8'h7E, 0, 0);

    // glitch on index 2, start held high through the sweep
    sweep(8'h7A, 8'h7A, 1, 1);
    tick();
    check("one_sweep", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
